csa_resolve: RTL and testbench
==============================

# csa_resolve

Sequential carry-propagate stage that sits directly downstream of the carry-save adder tree in the Booth multiplier datapath. It accepts one redundant pair (sum vector, carry vector) per transaction and resolves it into a single binary result. It adds one CHUNK-wide slice per cycle, so no full-width carry chain appears on the critical path. Valid/ready handshakes are used on both sides.

## Interface
- WIDTH, 320: width of the sum/carry vectors and of the result. 320 covers a 256x64 product.
- CHUNK, 32: bits resolved per cycle. WIDTH % CHUNK == 0 is required; a violation is an elaboration error.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream vectors valid.
- s_ready  out  1  block can accept a transaction.
- s_sum  in  WIDTH  CSA sum vector. Bit i has weight 2^i.
- s_carry  in  WIDTH  CSA carry vector. Bit i has weight 2^(i+1).
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_result  out  WIDTH  (s_sum + 2*s_carry) mod 2^WIDTH.
- m_ext  out  2  bits WIDTH+1:WIDTH of the exact sum.

## Operation
- N = WIDTH/CHUNK. Counter width is $clog2(N), minimum 1.
- States: IDLE, RUN, DONE.
- IDLE
  - s_ready = 1.
  - On s_valid && s_ready:
    - latch A = s_sum;
    - latch B = {s_carry[WIDTH-2:0], 1'b0};
    - latch top = s_carry[WIDTH-1];
    - clear the chunk counter k and the carry flop cy;
    - go to RUN.
- RUN
  - Each cycle: {cy, m_result[k*CHUNK +: CHUNK]} <= A chunk k + B chunk k + cy; then k <= k+1.
  - When k == N-1: m_ext <= cy_out + top (2-bit add), then go to DONE.
- DONE
  - m_valid = 1. m_result and m_ext are held stable.
  - On m_ready, go to IDLE.
- m_valid is never asserted outside DONE.
- s_ready is 0 in RUN, and in DONE except as allowed under Configuration.
- Inputs are sampled only on the accept edge. Changes on s_sum/s_carry afterwards have no effect.
- m_result chunks not yet written hold their previous values. They are only meaningful once m_valid is high.
- Arithmetic is unsigned. The exact value is {m_ext, m_result} = s_sum + 2*s_carry. Its maximum is below 3*2^WIDTH, so 2 extension bits suffice.

## Timing
- Reset: state = IDLE, s_ready = 1, m_valid = 0, m_result = 0, m_ext = 0, k = 0, cy = 0.
- Reset asserted mid-RUN or mid-DONE aborts the transaction immediately. No result is produced.
- Latency: the accept edge is t. m_valid is high after edge t+N.
- Without the macro, the next s_ready is high one cycle after the m_ready edge. Throughput is one result per N+2 cycles.
- Downstream back-pressure (m_ready = 0) holds DONE indefinitely with outputs stable.
- The critical path is one CHUNK-bit adder plus the carry flop.

## Configuration
- CSA_RESOLVE_BACK2BACK_EN
  - Defined: in DONE, s_ready = m_ready. When m_ready && s_valid coincide, the result is released and a new transaction is accepted on the same edge, going DONE -> RUN directly. Throughput is one result per N+1 cycles.
  - Undefined: s_ready is asserted only in IDLE.

## Structure
- Package csa_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH/CHUNK localparams;
  - a function computing N and the counter width.
- One sub-module, cpa_chunk: a CHUNK-wide adder with cin/cout, instantiated once and muxed by k.
- The FSM, counter and operand registers live in csa_resolve.

## Test plan
- WIDTH=320, CHUNK=32, s_sum=1, s_carry=1 -> m_result=3, m_ext=0; m_valid rises 10 cycles after accept.
- s_sum = all ones, s_carry = 0...01 -> m_result=1, m_ext=2'b01. Checks the carry ripple through all 10 chunks.
- s_sum = all ones, s_carry = all ones -> m_result = 2^320-3 (all ones except bit 1), m_ext=2'b10. This is the maximum case.
- m_ready held low for 20 cycles in DONE -> m_valid stays 1, m_result stable, s_ready=0; release gives IDLE on the next edge.
- rst pulsed at RUN cycle 5 -> all outputs 0 and IDLE on the next edge; a new transaction afterwards completes correctly.
- Macro defined, s_valid held high with m_ready=1 over 3 transactions -> consecutive m_valid pulses spaced 11 cycles apart. Macro undefined -> spacing of 12 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: shared state type, default sizes and chunk-count helpers for csa_resolve
package csa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CSA_WIDTH = 320;
  localparam int CSA_CHUNK = 32;
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int cnt_width(input int width, input int chunk);
    return (width / chunk) > 1 ? $clog2(width / chunk) : 1;
  endfunction
endpackage

// File: rtl/csa_resolve_cpa_chunk.sv
// cpa_chunk: CHUNK-wide binary adder with carry in/out
module cpa_chunk #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save pair into binary, one CHUNK slice per cycle
// CSA_RESOLVE_BACK2BACK_EN lets DONE release and accept on the same edge.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic [WIDTH-1:0] s_carry,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_result,
  output logic [1:0]       m_ext
);
  localparam int N = num_chunks(WIDTH, CHUNK);
  localparam int KW = cnt_width(WIDTH, CHUNK);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_resolve: WIDTH must be a multiple of CHUNK");
  end
  state_t state;
  logic [WIDTH-1:0] a, b;
  logic top, cy, co;
  logic [KW-1:0] k;
  logic [CHUNK-1:0] ca, cb, cs;
  logic accept;
  assign m_valid = state == DONE;
`ifdef CSA_RESOLVE_BACK2BACK_EN
  assign s_ready = state == IDLE || (state == DONE && m_ready);
`else
  assign s_ready = state == IDLE;
`endif
  assign accept = s_valid && s_ready;
  assign ca = a[int'(k)*CHUNK +: CHUNK];
  assign cb = b[int'(k)*CHUNK +: CHUNK];
  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (.a(ca), .b(cb), .cin(cy), .s(cs), .cout(co));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      top <= 1'b0;
      cy <= 1'b0;
      k <= '0;
      m_result <= '0;
      m_ext <= '0;
    end else begin
      // Operand load is shared by IDLE and the back-to-back DONE path
      if (accept) begin
        a <= s_sum;
        b <= {s_carry[WIDTH-2:0], 1'b0};
        top <= s_carry[WIDTH-1];
        cy <= 1'b0;
        k <= '0;
        state <= RUN;
      end else if (state == DONE && m_ready) begin
        state <= IDLE;
      end
      if (state == RUN) begin
        m_result[int'(k)*CHUNK +: CHUNK] <= cs;
        cy <= co;
        k <= k + KW'(1);
        if (k == KW'(N - 1)) begin
          m_ext <= {1'b0, co} + {1'b0, top};
          k <= '0;
          state <= DONE;
        end
      end
      if (state != IDLE && state != RUN && state != DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: directed and random checks of csa_resolve against exact arithmetic
module tb_csa_resolve;
  localparam int W = 320;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [W-1:0] s_sum = '0;
  logic [W-1:0] s_carry = '0;
  logic s_ready, m_valid;
  logic [W-1:0] m_result;
  logic [1:0] m_ext;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  csa_resolve #(.WIDTH(W), .CHUNK(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_sum(s_sum), .s_carry(s_carry), .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_ext(m_ext)
  );
  task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [W+1:0] ref_sum(input logic [W-1:0] s, input logic [W-1:0] c);
    return {2'b00, s} + ({2'b00, c} << 1);
  endfunction
  task automatic wait_ready(input string tag);
    int w = 0;
    while (!s_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({tag, " ready"}, {{W{1'b0}}, 1'b0, s_ready}, 1);
  endtask
  task automatic run_txn(input string tag, input logic [W-1:0] s, input logic [W-1:0] c, input int hold);
    logic [W+1:0] exp;
    int lat;
    exp = ref_sum(s, c);
    wait_ready(tag);
    s_sum = s;
    s_carry = c;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sum = rand_vec();
    s_carry = rand_vec();
    lat = 0;
    while (!m_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, (W+2)'(lat), 10);
    check({tag, " result"}, {m_ext, m_result}, exp);
    check({tag, " busy"}, {{W{1'b0}}, s_ready}, 0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, " hold_result"}, {m_ext, m_result}, exp);
      check({tag, " hold_flags"}, {{W{1'b0}}, m_valid, s_ready}, 2);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, " release"}, {{W{1'b0}}, m_valid, s_ready}, 1);
  endtask
  initial begin
    int cyc;
    int t[$];
    logic [W-1:0] ts, tc;
    #12;
    check("reset_async", {{(W-2){1'b0}}, s_ready, m_valid, m_ext}, {{(W-2){1'b0}}, 4'b1000});
    check("reset_result", {2'b00, m_result}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_txn("one_one", W'(1), W'(1), 0);
    run_txn("ripple", '1, W'(1), 0);
    run_txn("max", '1, '1, 0);
    run_txn("backpressure", rand_vec(), rand_vec(), 20);
    for (int i = 0; i < 8; i++) run_txn("random", rand_vec(), rand_vec(), i % 3);
    wait_ready("abort");
    s_sum = rand_vec();
    s_carry = rand_vec();
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_async", {{(W-2){1'b0}}, s_ready, m_valid, m_ext}, {{(W-2){1'b0}}, 4'b1000});
    check("abort_result", {2'b00, m_result}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_idle", {{W{1'b0}}, m_valid, s_ready}, 1);
    run_txn("after_abort", rand_vec(), rand_vec(), 1);
    ts = rand_vec();
    tc = rand_vec();
    s_sum = ts;
    s_carry = tc;
    s_valid = 1'b1;
    m_ready = 1'b1;
    cyc = 0;
    while (t.size() < 3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_valid) begin
        t.push_back(cyc);
        check("stream_result", {m_ext, m_result}, ref_sum(ts, tc));
      end
    end
    s_valid = 1'b0;
    check("stream_count", (W+2)'(t.size()), 3);
    if (t.size() == 3) begin
`ifdef CSA_RESOLVE_BACK2BACK_EN
      check("stream_gap1", (W+2)'(t[1] - t[0]), 11);
      check("stream_gap2", (W+2)'(t[2] - t[1]), 11);
`else
      check("stream_gap1", (W+2)'(t[1] - t[0]), 12);
      check("stream_gap2", (W+2)'(t[2] - t[1]), 12);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
